// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execute-stage ALU.
// Valid/ready semantics on both sides: a transfer happens on a rising edge
// where valid and ready are both high; the initiator holds its payload stable
// while valid is high and ready is low, and ready may depend combinationally
// on the far side's ready (out_ready -> in_ready) but never on valid.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    // Request side: core -> ALU
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;

    // Response side: ALU -> core
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    // The core drives requests and consumes results.
    modport master (
        output in_valid,
        output operation,
        output src_a,
        output src_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero,
        input  illegal
    );

    // The ALU accepts requests and produces results.
    modport slave (
        input  in_valid,
        input  operation,
        input  src_a,
        input  src_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output zero,
        output illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Logic/arithmetic ops finish in one cycle; shifts walk
// one bit per cycle through an accumulator so a single 1-bit shifter serves
// every shift amount. A three-state FSM (IDLE/SHIFT/DONE) owns the handshake
// and holds result/zero/illegal stable until the consumer takes them.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_unit_if.slave       bus,
    output logic [1:0]           dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [SHW-1:0] CNT_ZERO = '0;
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             out_valid_q;

    logic             in_ready;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_ill_d;
    logic [WIDTH-1:0] acc_d;

    // Ready in IDLE, or in DONE when the held result leaves on this same edge.
    assign in_ready = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign is_shift = (bus.operation == OP_SLL) ||
                      (bus.operation == OP_SRL) ||
                      (bus.operation == OP_SRA);
    assign amt      = bus.src_b[SHW-1:0];

    // Single-cycle datapath; a shift reaching here has amount 0 and passes src_a.
    always_comb begin
        alu_res_d = '0;
        alu_ill_d = 1'b0;
        case (bus.operation)
            OP_AND: alu_res_d = bus.src_a & bus.src_b;
            OP_OR:  alu_res_d = bus.src_a | bus.src_b;
            OP_ADD: alu_res_d = bus.src_a + bus.src_b;
            OP_SUB: alu_res_d = bus.src_a - bus.src_b;
            OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}},
                                 ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLL,
            OP_SRL,
            OP_SRA: alu_res_d = bus.src_a;
            default: begin
                alu_res_d = '0;
                alu_ill_d = 1'b1;
            end
        endcase
    end

    // One-bit step of the iterative shifter, direction taken from the captured op.
    always_comb begin
        acc_d = acc_q;
        case (op_q)
            OP_SLL:  acc_d = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_d = {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA:  acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_d = acc_q;
        endcase
    end

    // Control FSM with registered result/zero/illegal/out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= CNT_ZERO;
            op_q        <= OP_AND;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_shift && (amt != CNT_ZERO)) begin
                            // Multi-cycle shift: capture source and amount.
                            acc_q       <= bus.src_a;
                            cnt_q       <= amt;
                            op_q        <= bus.operation;
                            out_valid_q <= 1'b0;
                            state_q     <= S_SHIFT;
                        end else begin
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            illegal_q   <= alu_ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && bus.out_ready) begin
                        // Result consumed and nothing new offered.
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a behavioural model computes each
// accepted request's result and due cycle, a negedge monitor checks every
// meaningful output cycle against it, and directed steps pin literal values.
module tb_alu_exec_unit;

    localparam int W = 34;  // {illegal, zero, result[31:0]}

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    bit           head_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: what the op must produce, from its definition.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        int          sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = a << sh;
            4'b0100: r = a >> sh;
            4'b0101: r = $unsigned($signed(a) >>> sh);
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    // Extra cycles beyond the accept edge before out_valid rises.
    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'b0011 || op == 4'b0100 || op == 4'b0101) return int'(b[4:0]);
        return 0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic exp_ready;
        if (rst_n) begin
            exp_ready = (exp_q.size() == 0) || (bus.out_valid && bus.out_ready);
            check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: out_valid=1 but expected nothing outstanding (cycle %0d)", cyc);
                end else begin
                    if (!head_seen) begin
                        check("latency", 64'(cyc), 64'(due_q[0]));
                        head_seen = 1;
                    end
                    check("out_word", {30'd0, bus.illegal, bus.zero, bus.result}, {30'd0, exp_q[0]});
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.operation, bus.src_a, bus.src_b));
                due_q.push_back(cyc + 1 + model_lat(bus.operation, bus.src_b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Returns at #1 after the accept edge.
    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: no accept within 100 cycles, got in_ready=0 expected 1", name);
        end
        @(posedge clk);
        #1;
    endtask

    // Called right after wait_accept; checks literal output and latency.
    task automatic wait_out(input string name, input logic [31:0] res, input logic z,
                            input logic ill, input int lat);
        bit ok = 0;
        int t0 = cyc;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: out_valid timeout, got 0 expected 1", name);
        end else begin
            check({name, "_res"}, {32'd0, bus.result}, {32'd0, res});
            check({name, "_zero"}, {63'd0, bus.zero}, {63'd0, z});
            check({name, "_ill"}, {63'd0, bus.illegal}, {63'd0, ill});
            check({name, "_lat"}, 64'(cyc - t0), 64'(lat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({name, "_result"}, {32'd0, bus.result}, 64'd0);
        check({name, "_zero"}, {63'd0, bus.zero}, 64'd0);
        check({name, "_illegal"}, {63'd0, bus.illegal}, 64'd0);
        check({name, "_state"}, {62'd0, dbg_state}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  s_op[4];
    logic [31:0] s_a[4];
    logic [31:0] s_b[4];

    initial begin
        int t0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 4'd0;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.out_ready = 1'b1;

        s_op[0] = 4'b0000; s_a[0] = 32'h0000000F; s_b[0] = 32'h000000FF;
        s_op[1] = 4'b0001; s_a[1] = 32'h000000F0; s_b[1] = 32'h0000000F;
        s_op[2] = 4'b0111; s_a[2] = 32'hFFFFFFFF; s_b[2] = 32'h00000001;
        s_op[3] = 4'b0111; s_a[3] = 32'h00000001; s_b[3] = 32'hFFFFFFFF;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model against hand-computed values.
        check("model_add", 64'(model(4'b0010, 32'h7FFFFFFF, 32'd1)), 64'h0_80000000);
        check("model_sub", 64'(model(4'b0110, 32'd5, 32'd5)), 64'h1_00000000);
        check("model_sra", 64'(model(4'b0101, 32'h80000000, 32'd31)), 64'h0_FFFFFFFF);
        check("model_slt", 64'(model(4'b0111, 32'hFFFFFFFF, 32'd1)), 64'h0_00000001);
        check("model_ill", 64'(model(4'b1111, 32'd3, 32'd4)), 64'h3_00000000);

        // ADD overflow wraps, then SUB to zero.
        drive(4'b0010, 32'h7FFFFFFF, 32'd1); wait_accept("add"); idle();
        wait_out("add", 32'h80000000, 1'b0, 1'b0, 0);
        drive(4'b0110, 32'd5, 32'd5); wait_accept("sub"); idle();
        wait_out("sub", 32'd0, 1'b1, 1'b0, 0);

        // Stream four single-cycle ops with no bubbles.
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(s_op[i], s_a[i], s_b[i]);
            wait_accept("stream");
        end
        idle();
        check("stream_cycles", 64'(cyc - t0), 64'd4);
        repeat (3) begin @(posedge clk); #1; end

        // Shifts: full-length SRA, shift by 0, amount taken from low bits only.
        drive(4'b0101, 32'h80000000, 32'd31); wait_accept("sra31"); idle();
        wait_out("sra31", 32'hFFFFFFFF, 1'b0, 1'b0, 31);
        drive(4'b0011, 32'd1, 32'd0); wait_accept("sll0"); idle();
        wait_out("sll0", 32'd1, 1'b0, 1'b0, 0);
        drive(4'b0100, 32'h80000000, 32'h21); wait_accept("srl1"); idle();
        wait_out("srl1", 32'h40000000, 1'b0, 1'b0, 1);

        // Back-pressure: hold out_ready low in DONE with a request pending.
        bus.out_ready = 1'b0;
        drive(4'b0010, 32'd10, 32'd20); wait_accept("hold_add");
        drive(4'b0110, 32'd9, 32'd4);
        repeat (5) begin @(posedge clk); #1; end
        check("hold_result", {32'd0, bus.result}, 64'd30);
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.out_ready = 1'b1;
        wait_accept("hold_release"); idle();
        wait_out("hold_next", 32'd5, 1'b0, 1'b0, 0);

        // Unsupported op code, then a legal op clears illegal.
        drive(4'b1111, 32'h1234, 32'h5678); wait_accept("illegal"); idle();
        wait_out("illegal", 32'd0, 1'b1, 1'b1, 0);
        drive(4'b0010, 32'd1, 32'd1); wait_accept("after_ill"); idle();
        wait_out("after_ill", 32'd2, 1'b0, 1'b0, 0);

        // Reset in the middle of a 20-bit shift discards it.
        drive(4'b0100, 32'hFFFFFFFF, 32'd20); wait_accept("srl20"); idle();
        repeat (10) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        head_seen = 0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(4'b0010, 32'd2, 32'd3); wait_accept("post_reset"); idle();
        wait_out("post_reset", 32'd5, 1'b0, 1'b0, 0);

        repeat (3) begin @(posedge clk); #1; end
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
